// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary pointer conversion used by both
// the read-side and write-side controllers.
package fifo_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin, input int unsigned width);
    ptr_t masked;
    masked = bin & ((ptr_t'(1) << width) - ptr_t'(1));
    return masked ^ (masked >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it within width.
  function automatic ptr_t gray2bin(input ptr_t gray, input int unsigned width);
    ptr_t bin;
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
      if (i < int'(width)) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: synchronized pointers, RAM read port and the
// valid/ready output stream.
interface fifo_rd_ctrl_if #(
  parameter int AW = 4,
  parameter int W  = 32
);

  logic [AW:0]   wr_ptr_gray_sync;
  logic [AW:0]   rd_ptr_gray;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [W-1:0]  ram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW+1:0] rd_level;

  modport master (
    input  wr_ptr_gray_sync, ram_rdata, out_ready,
    output rd_ptr_gray, ram_ren, ram_raddr, out_valid, out_data, rd_level
  );

  modport slave (
    output wr_ptr_gray_sync, ram_rdata, out_ready,
    input  rd_ptr_gray, ram_ren, ram_raddr, out_valid, out_data, rd_level
  );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer: head holds the oldest word, tail the next one.
// Push and pop may happen together; the caller never overfills it.
module fifo_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head_data
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // With one entry the new word becomes the head directly.
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: issues RAM reads against the
// synchronized write pointer and streams words out through a 2-entry skid.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = 32
) (
  input logic            clk,
  input logic            rst_n,
  fifo_rd_ctrl_if.master bus
);

  localparam int unsigned PTR_W = AW + 1;

  logic [AW:0]  rd_ptr_bin_q, rd_ptr_bin_d;
  logic [AW:0]  rd_ptr_gray_q, rd_ptr_gray_d;
  logic         pending_q, pending_d;
  logic [AW:0]  wr_bin;
  logic [AW:0]  unread;
  logic         ram_empty;
  logic         out_valid;
  logic         pop;
  logic         issue;
  logic [2:0]   fill_after_pop;
  logic [1:0]   occ;
  logic [W-1:0] head_data;

  // Issue only while the skid can absorb the word that lands next cycle;
  // rst_n gating keeps ram_ren low for the whole reset window.
  always_comb begin
    wr_bin         = (AW+1)'(gray2bin(PTR_MAX_W'(bus.wr_ptr_gray_sync), PTR_W));
    ram_empty      = (wr_bin == rd_ptr_bin_q);
    out_valid      = (occ != 2'd0);
    pop            = out_valid & bus.out_ready;
    fill_after_pop = {1'b0, occ} + {2'b00, pending_q} - {2'b00, pop};
    issue          = rst_n && !ram_empty && (fill_after_pop <= 3'd1);
    rd_ptr_bin_d   = rd_ptr_bin_q + {{AW{1'b0}}, issue};
    pending_d      = issue;
    rd_ptr_gray_d  = (AW+1)'(bin2gray(PTR_MAX_W'(rd_ptr_bin_q), PTR_W));
    unread         = wr_bin - rd_ptr_bin_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      pending_q     <= pending_d;
    end
  end

  fifo_skid2 #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_q),
    .push_data (bus.ram_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  assign bus.rd_ptr_gray = rd_ptr_gray_q;
  assign bus.ram_ren     = issue;
  assign bus.ram_raddr   = rd_ptr_bin_q[AW-1:0];
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = head_data;
  assign bus.rd_level    = {1'b0, unread} + (AW+2)'(pending_q) + (AW+2)'(occ);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural RAM, write-pointer driver and a
// scoreboard queue of words in write order.
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int add_words;
    bit ready;
    int cycles;
    int exp_level;
    bit exp_valid;
    int exp_reads;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fifo_rd_ctrl_if #(.AW(AW), .W(W)) bus ();

  fifo_rd_ctrl #(.AW(AW), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  logic [AW:0]   wr_bin    = '0;
  logic [AW:0]   exp_rd    = '0;
  logic [AW:0]   rd_bin_d1 = '0;
  logic [AW:0]   prev_gray = '0;
  logic          hold_valid = 1'b0;
  logic [W-1:0]  hold_data  = '0;
  logic          ren_prev   = 1'b0;
  int            checks     = 0;
  int            errors     = 0;
  int            issue_cnt  = 0;
  int            wrap_seen  = 0;
  vec_t          vecs [7];

  function automatic logic [AW:0] toGray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addWords(input int n);
    logic [W-1:0] data;
    for (int i = 0; i < n; i++) begin
      data = $urandom;
      mem[wr_bin[AW-1:0]] = data;
      exp_q.push_back(data);
      wr_bin = wr_bin + 1'b1;
    end
    bus.wr_ptr_gray_sync = toGray(wr_bin);
  endtask

  task automatic applyStimulus(input int n, input bit ready);
    @(posedge clk);
    #2;
    addWords(n);
    bus.out_ready = ready;
  endtask

  // RAM with one cycle read latency
  always @(posedge clk) begin
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd     = '0;
      rd_bin_d1  = '0;
      prev_gray  = '0;
      hold_valid = 1'b0;
      ren_prev   = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("gray_track", bus.rd_ptr_gray, toGray(rd_bin_d1));
      checkOutput("gray_onebit", ($countones(bus.rd_ptr_gray ^ prev_gray) <= 1), 1'b1);
      prev_gray = bus.rd_ptr_gray;
      rd_bin_d1 = exp_rd;
      ren_prev  = bus.ram_ren;
      if (bus.ram_ren) begin
        checkOutput("raddr", bus.ram_raddr, exp_rd[AW-1:0]);
        checkOutput("ren_not_empty", (exp_rd != wr_bin), 1'b1);
        if (exp_rd == '1) wrap_seen++;
        exp_rd = exp_rd + 1'b1;
        issue_cnt++;
      end
      if (hold_valid) begin
        checkOutput("valid_hold", bus.out_valid, 1'b1);
        checkOutput("data_hold", bus.out_data, hold_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) checkOutput("pop_expected", 1'b0, 1'b1);
        else                   checkOutput("pop_data", bus.out_data, exp_q.pop_front());
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_data  = bus.out_data;
    end
  end

  initial begin
    int base;
    int cnt;
    int first;
    int last;
    int remaining;
    logic [AW:0] lvl;

    vecs[0] = '{3,  1'b0, 4,  3,  1'b1, 2};
    vecs[1] = '{0,  1'b1, 12, 0,  1'b0, 3};
    vecs[2] = '{1,  1'b0, 3,  1,  1'b1, 4};
    vecs[3] = '{0,  1'b1, 3,  0,  1'b0, 4};
    vecs[4] = '{16, 1'b0, 4,  16, 1'b1, 6};
    vecs[5] = '{0,  1'b1, 24, 0,  1'b0, 20};
    vecs[6] = '{2,  1'b1, 5,  0,  1'b0, 22};

    bus.out_ready        = 1'b0;
    bus.wr_ptr_gray_sync = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", bus.out_valid, 1'b0);
    checkOutput("rst_ren", bus.ram_ren, 1'b0);
    checkOutput("rst_gray", bus.rd_ptr_gray, '0);
    checkOutput("rst_level", bus.rd_level, '0);
    checkOutput("rst_data", bus.out_data, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput("idle_valid", bus.out_valid, 1'b0);
      checkOutput("idle_ren", bus.ram_ren, 1'b0);
      checkOutput("idle_gray", bus.rd_ptr_gray, '0);
      checkOutput("idle_level", bus.rd_level, '0);
    end

    @(posedge clk); #2;
    mem[0] = 32'hA5;
    exp_q.push_back(32'hA5);
    wr_bin = 1;
    bus.wr_ptr_gray_sync = toGray(wr_bin);
    #1;
    checkOutput("lat_ren", bus.ram_ren, 1'b1);
    checkOutput("lat_raddr", bus.ram_raddr, '0);
    @(negedge clk); #1;
    checkOutput("lat_valid_t0", bus.out_valid, 1'b0);
    @(negedge clk); #1;
    checkOutput("lat_valid_t1", bus.out_valid, 1'b0);
    checkOutput("lat_gray_t1", bus.rd_ptr_gray, 5'd0);
    checkOutput("lat_ren_t1", bus.ram_ren, 1'b0);
    @(negedge clk); #1;
    checkOutput("lat_valid_t2", bus.out_valid, 1'b1);
    checkOutput("lat_data_t2", bus.out_data, 32'hA5);
    checkOutput("lat_gray_t2", bus.rd_ptr_gray, 5'd1);
    applyStimulus(0, 1'b1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("lat_drained", bus.out_valid, 1'b0);
    checkOutput("lat_level", bus.rd_level, '0);

    applyStimulus(16, 1'b1);
    remaining = 24;
    cnt = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (bus.out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #2;
      lvl = wr_bin - exp_rd;
      if (remaining > 0 && int'(lvl) < DEPTH) begin
        addWords(1);
        remaining--;
      end
    end
    checkOutput("stream_words", cnt, 40);
    checkOutput("stream_no_bubble", last - first + 1, 40);
    checkOutput("stream_wrap", (wrap_seen != 0), 1'b1);
    checkOutput("stream_sb_empty", exp_q.size(), 0);

    base = issue_cnt;
    applyStimulus(5, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("bp_reads", issue_cnt - base, 2);
    checkOutput("bp_level", bus.rd_level, 5);
    checkOutput("bp_valid", bus.out_valid, 1'b1);
    checkOutput("bp_head", bus.out_data, exp_q[0]);
    applyStimulus(0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checkOutput("bp_release_valid", bus.out_valid, 1'b1);
    end
    @(negedge clk); #1;
    checkOutput("bp_release_done", bus.out_valid, 1'b0);
    checkOutput("bp_release_reads", issue_cnt - base, 5);

    base = issue_cnt;
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].add_words, vecs[v].ready);
      repeat (vecs[v].cycles) @(negedge clk);
      #1;
      checkOutput("vec_level", bus.rd_level, vecs[v].exp_level);
      checkOutput("vec_valid", bus.out_valid, vecs[v].exp_valid);
      checkOutput("vec_reads", issue_cnt - base, vecs[v].exp_reads);
    end
    checkOutput("vec_sb_empty", exp_q.size(), 0);

    applyStimulus(10, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    checkOutput("mid_pending_setup", ren_prev, 1'b1);
    rst_n = 1'b0;
    wr_bin = '0;
    bus.wr_ptr_gray_sync = '0;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_ren", bus.ram_ren, 1'b0);
    checkOutput("mid_rst_gray", bus.rd_ptr_gray, '0);
    checkOutput("mid_rst_data", bus.out_data, '0);
    checkOutput("mid_rst_level", bus.rd_level, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checkOutput("mid_late_dropped", bus.out_valid, 1'b0);
      checkOutput("mid_post_level", bus.rd_level, '0);
      checkOutput("mid_post_ren", bus.ram_ren, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller of the dual-clock FIFO; lives entirely in the read clock domain. It consumes the write pointer after the two-flop synchronizer stage and drives the FIFO RAM read port. It presents popped words on a valid/ready interface and publishes its own Gray-coded read pointer for synchronization back into the write domain.

## Interface
- `AW`, 4: RAM address width; FIFO depth is 2^AW.
- `W`, 32: data word width.
- `clk`  in  1  read-domain clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `wr_ptr_gray_sync`  in  AW+1  write pointer, Gray-coded, already synchronized into `clk`.
- `rd_ptr_gray`  out  AW+1  registered Gray read pointer, to the write-domain synchronizer.
- `ram_ren`  out  1  RAM read enable.
- `ram_raddr`  out  AW  RAM read address; equals `rd_ptr_bin[AW-1:0]`.
- `ram_rdata`  in  W  RAM read data; valid exactly one cycle after `ram_ren`.
- `out_valid`  out  1  head word available.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  W  head word.
- `rd_level`  out  AW+2  words visible to the reader: `(wr_bin - rd_bin) + pending + occ`.

## Operation
- State:
  - `rd_ptr_bin` [AW:0]: binary read pointer.
  - `pending`: one bit; a RAM read was issued last cycle.
  - 2-entry output skid buffer holding `occ` (0..2) words.
- `wr_bin = gray2bin(wr_ptr_gray_sync)`, computed combinationally. `ram_empty = (wr_bin == rd_ptr_bin)`, full AW+1-bit compare including the wrap bit.
- `pop = out_valid & out_ready`.
- Issue rule: `ram_ren = !ram_empty && (occ + pending - pop) <= 1`. On issue, `rd_ptr_bin` increments modulo 2^(AW+1).
- Next cycle with `pending` = 1: `ram_rdata` is written into the skid buffer tail.
- `out_valid = (occ != 0)`. `out_data` is the oldest entry. Order is strictly FIFO.
- Simultaneous pop and fill: `occ` is unchanged, the head advances, and the new word goes to the tail.
- `rd_ptr_gray <= bin2gray(rd_ptr_bin)` is registered. It is driven from a flop only and never from logic, so it changes at most one bit per cycle.
- The synchronized pointer is trusted as-is. There is no checking for illegal Gray steps.
- `out_valid` must not drop while `!out_ready`. `out_data` must hold stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) clears the following immediately, independent of `clk`:
  - `rd_ptr_bin`, `rd_ptr_gray`, `pending`, `occ` → 0.
  - `out_valid` = 0, `ram_ren` = 0.
  - `out_data` → 0 (its reset value is don't-care, but it is driven to 0).
- Latency:
  - Non-empty pointer seen in cycle t → `ram_ren` high in t → word captured at end of t+1 → `out_valid` high in t+2.
  - Pointer update: `rd_ptr_gray` reflects an issue in t from cycle t+2.
- Throughput: one word per cycle sustained with `out_ready` held high and the RAM non-empty.
- Wrap: at `rd_ptr_bin` = 2^(AW+1)-1, the next value is 0. `ram_raddr` wraps at 2^AW.
- Empty: `ram_ren` stays 0. Words already pending or buffered still drain.
- Backpressure with `out_ready` = 0: at most two words are buffered, and issue stops once `occ + pending` = 2.
- Reset mid-operation: any in-flight `pending` read is discarded and its `ram_rdata` ignored. Buffered words are lost. This matches the write side being reset together.

## Structure
- The shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterized by width.
  - the pointer typedef.
- The write-side controller uses the same package.
- One sub-module: `fifo_skid2`, the 2-entry valid/ready skid buffer with push, pop, `occ`, and async reset.
- The pointer logic stays in `fifo_rd_ctrl`.

## Test plan
- Reset, then hold `wr_ptr_gray_sync` = 0 → `out_valid`, `ram_ren`, `rd_ptr_gray` stay 0 and `rd_level` = 0.
- Step `wr_ptr_gray_sync` to `bin2gray(1)`, with `ram_rdata` = 0xA5 on the cycle after `ram_ren` → `out_valid` rises exactly 2 cycles later with `out_data` = 0xA5. `rd_ptr_gray` = 1 two cycles after issue.
- Run 40 words with `AW` = 4 and `out_ready` = 1 → one word per cycle in order, `ram_raddr` wraps 15→0, `rd_ptr_bin` wraps 31→0, and `rd_ptr_gray` changes one bit per step.
- Set 5 words available with `out_ready` = 0 → exactly 2 reads are issued, `rd_level` = 5, and `out_data` is stable. Then release `out_ready` → the remaining 3 words arrive in order with no bubble after the first.
- Assert `rst_n` low mid-stream with `pending` = 1 → all outputs clear asynchronously before the next edge, and the late `ram_rdata` is not captured.
